// File: rtl/prio_grant_decoder_pkg.sv
// Shared types and defaults for the priority grant decoder and its encoder bench.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: prio_dec_state_t FSM encoding, PRIO_WIDTH / PRIO_HOLD defaults.
package prio_pkg;

    localparam int PRIO_WIDTH = 8;
    localparam int PRIO_HOLD  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } prio_dec_state_t;

endpackage

// File: rtl/prio_grant_decoder_if.sv
// Encoded-index in / one-hot grant out bundle between encoder, decoder and consumer.
// Latency: n/a (wires only).
// Backpressure: ready from decoder to encoder; grant_ack from consumer to decoder.
// Ports: enc/valid/ready (index beat), grant/grant_valid/grant_ack (grant), busy, err.
// master drives the beats and the ack; slave is the decoder.
interface prio_grant_decoder_if #(
    parameter int WIDTH      = prio_pkg::PRIO_WIDTH,
    parameter int ADDR_WIDTH = $clog2(WIDTH)
) ();

    logic [ADDR_WIDTH-1:0] enc;
    logic                  valid;
    logic                  ready;
    logic [WIDTH-1:0]      grant;
    logic                  grant_valid;
    logic                  grant_ack;
    logic                  busy;
    logic                  err;

    modport master (
        output enc, valid, grant_ack,
        input  ready, grant, grant_valid, busy, err
    );

    modport slave (
        input  enc, valid, grant_ack,
        output ready, grant, grant_valid, busy, err
    );

endinterface

// File: rtl/prio_dec_fifo.sv
// Two-entry index buffer between the encoder beat and the grant FSM.
// Latency: data pushed at an edge is visible on dout after that edge.
// Backpressure: full when two entries held; push while full and pop while empty are ignored.
// Ports: clk, rst (sync, active-high), push/din, pop/dout, full, empty.
module prio_dec_fifo #(
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] din,
    output logic [ADDR_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);

    logic [ADDR_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage carries no reset: contents are only read when count says valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/prio_grant_decoder.sv
// Turns encoded winner indices back into a registered one-hot grant with min hold and a gap cycle.
// Latency: 2 cycles valid -> grant_valid from idle; back-to-back period HOLD+1 cycles.
// Backpressure: ready drops when the 2-entry buffer is full; grant held until grant_ack after HOLD.
// Ports: clk, rst (sync, active-high), bus (slave: enc/valid/ready, grant/grant_valid/grant_ack, busy, err).
// Option: PRIO_DEC_RANGE_CHECK_EN drops out-of-range indices and pulses err instead of granting zero.
module prio_grant_decoder #(
    parameter int WIDTH      = prio_pkg::PRIO_WIDTH,
    parameter int ADDR_WIDTH = $clog2(WIDTH),
    parameter int HOLD       = prio_pkg::PRIO_HOLD
) (
    input  logic                  clk,
    input  logic                  rst,
    prio_grant_decoder_if.slave   bus
);

    import prio_pkg::*;

    localparam int             CW        = $clog2(HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LOAD = CW'(HOLD - 1);

    prio_dec_state_t       state;
    prio_dec_state_t       next_state;
    logic [CW-1:0]         hold_cnt;
    logic                  hold_done;
    logic [WIDTH-1:0]      grant_q;
    logic                  grant_valid_q;
    logic [WIDTH-1:0]      dec;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ADDR_WIDTH-1:0] fifo_dout;

    assign bus.ready = !fifo_full && !rst;
    assign accept    = bus.valid && bus.ready;

`ifdef PRIO_DEC_RANGE_CHECK_EN
    localparam logic [ADDR_WIDTH:0] WIDTH_W = (ADDR_WIDTH + 1)'(WIDTH);

    logic in_range;
    logic err_q;

    // Out-of-range beats are consumed (ready unaffected) but never buffered.
    assign in_range = ({1'b0, bus.enc} < WIDTH_W);
    assign push     = accept && in_range;
    assign bus.err  = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !in_range;
        end
    end
`else
    assign push    = accept;
    assign bus.err = 1'b0;
`endif

    prio_dec_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (bus.enc),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // An index with no matching bit decodes to all-zero rather than wrapping.
    always_comb begin
        dec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (fifo_dout == ADDR_WIDTH'(i)) begin
                dec[i] = 1'b1;
            end
        end
    end

    assign hold_done = (hold_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty) next_state = GRANT;
            GRANT:   if (hold_done && bus.grant_ack) next_state = GAP;
            GAP:     next_state = fifo_empty ? IDLE : GRANT;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE, GAP: pop = !fifo_empty;
            default:   pop = 1'b0;
        endcase
    end

    // grant_valid tracks next_state so it is a flop aligned with grant itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            hold_cnt      <= '0;
        end else begin
            grant_valid_q <= (next_state == GRANT);
            if (pop) begin
                grant_q  <= dec;
                hold_cnt <= HOLD_LOAD;
            end else if (state == GRANT) begin
                if (!hold_done) begin
                    hold_cnt <= hold_cnt - 1'b1;
                end
                if (next_state == GAP) begin
                    grant_q <= '0;
                end
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = grant_valid_q;
    assign bus.busy        = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_prio_grant_decoder.sv
// Bench: WIDTH=8/HOLD=2 instance driven from a vector table plus corner sequences,
// and a WIDTH=6/HOLD=4 instance for early ack and out-of-range indices.
// Expected grants are queued at acceptance and compared when grant_valid rises.
module tb_prio_grant_decoder;

    localparam int W1 = 8;
    localparam int A1 = 3;
    localparam int H1 = 2;
    localparam int W2 = 6;
    localparam int A2 = 3;
    localparam int H2 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    prio_grant_decoder_if #(.WIDTH(W1), .ADDR_WIDTH(A1)) b1 ();
    prio_grant_decoder_if #(.WIDTH(W2), .ADDR_WIDTH(A2)) b2 ();

    prio_grant_decoder #(.WIDTH(W1), .ADDR_WIDTH(A1), .HOLD(H1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    prio_grant_decoder #(.WIDTH(W2), .ADDR_WIDTH(A2), .HOLD(H2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (b2)
    );

    typedef struct {
        logic [W1-1:0] grant;
        int            len;
    } sb_item_t;

    typedef struct {
        logic [A1-1:0] enc;
        int            ack_wait;
        logic [W1-1:0] exp_grant;
        int            exp_len;
    } vec_t;

    sb_item_t sb[$];
    sb_item_t cur_item;
    sb_item_t act_item;

    int errors = 0;
    int checks = 0;

    bit mon_en      = 1'b1;
    bit prev_gv     = 1'b0;
    bit b2b_pending = 1'b0;
    int cur_len     = 0;
    int zero_run    = 0;
    int gcnt        = 0;
    int ack_wait    = 0;
    bit last_acc    = 1'b0;

    logic          s_ready, s_gv, s_busy, s_err;
    logic [W1-1:0] s_grant;
    logic          s2_ready, s2_gv, s2_err;
    logic [W2-1:0] s2_grant;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        if (!mon_en) return;
        if (b1.grant_valid) begin
            if (!prev_gv) begin
                if (b2b_pending) check("gap_len", zero_run, 1);
                b2b_pending = 1'b0;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    act_item.len = 0;
                    act_item.grant = '0;
                    $display("FAIL grant_no_expect: got grant %0h expected none", b1.grant);
                end else begin
                    act_item = sb.pop_front();
                    check("grant_val", b1.grant, act_item.grant);
                end
                cur_len = 1;
            end else begin
                check("grant_stable", b1.grant, act_item.grant);
                cur_len++;
            end
        end else begin
            if (prev_gv) begin
                if (act_item.len != 0) check("grant_len", cur_len, act_item.len);
                else                   check("grant_min_hold", cur_len >= H1, 1);
                check("gap_zero", b1.grant, 0);
                b2b_pending = (sb.size() != 0);
                zero_run    = 0;
            end
            zero_run++;
        end
        prev_gv = b1.grant_valid;
    endtask

    // One cycle: sample at the falling edge, then return just after the rising edge.
    task automatic step();
        @(negedge clk);
        s_ready  = b1.ready;
        s_gv     = b1.grant_valid;
        s_grant  = b1.grant;
        s_busy   = b1.busy;
        s_err    = b1.err;
        s2_ready = b2.ready;
        s2_gv    = b2.grant_valid;
        s2_grant = b2.grant;
        s2_err   = b2.err;
        monitor();
        last_acc = b1.valid && b1.ready;
        if (last_acc) sb.push_back(cur_item);
        if (b1.grant_valid) gcnt++;
        else                gcnt = 0;
        b1.grant_ack = b1.grant_valid && (gcnt > ack_wait);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [A1-1:0] e, input logic [W1-1:0] g, input int len,
                        output int stalls);
        cur_item.grant = g;
        cur_item.len   = len;
        b1.enc   = e;
        b1.valid = 1'b1;
        stalls   = 0;
        step();
        while (!last_acc && stalls < 50) begin
            stalls++;
            step();
        end
        check("send_accepted", last_acc, 1);
        b1.valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        step();
        while (s_busy && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        vec_t          vecs[5];
        int            st;
        int            n;
        int            stalls[5];
        bit            saw;
        logic [W1-1:0] g;
        logic [W2-1:0] g2;

        vecs[0] = '{enc: 3'd5, ack_wait: 0, exp_grant: 8'b0010_0000, exp_len: 2};
        vecs[1] = '{enc: 3'd0, ack_wait: 6, exp_grant: 8'h01,        exp_len: 7};
        vecs[2] = '{enc: 3'd7, ack_wait: 1, exp_grant: 8'h80,        exp_len: 2};
        vecs[3] = '{enc: 3'd3, ack_wait: 2, exp_grant: 8'h08,        exp_len: 3};
        vecs[4] = '{enc: 3'd6, ack_wait: 4, exp_grant: 8'h40,        exp_len: 5};

        b1.enc = '0; b1.valid = 1'b0; b1.grant_ack = 1'b0;
        b2.enc = '0; b2.valid = 1'b0; b2.grant_ack = 1'b0;

        // Reset state
        step();
        check("ready_in_reset", s_ready, 0);
        step();
        rst = 1'b0;
        step();
        check("rst_ready", s_ready, 1);
        check("rst_grant", s_grant, 0);
        check("rst_gv", s_gv, 0);
        check("rst_busy", s_busy, 0);
        check("rst_err", s_err, 0);
        check("rst_ready2", s2_ready, 1);

        // Single-beat vectors: grant value, hold length, busy duration
        for (int i = 0; i < 5; i++) begin
            ack_wait = vecs[i].ack_wait;
            send(vecs[i].enc, vecs[i].exp_grant, vecs[i].exp_len, st);
            check("vec_stall", st, 0);
            count_busy(n);
            check("vec_busy_cycles", n, vecs[i].exp_len + 2);
        end

        // Back-pressure: fourth beat waits for the second grant's pop
        ack_wait = 3;
        for (int i = 1; i <= 4; i++) begin
            g = '0;
            g[i] = 1'b1;
            send(A1'(i), g, 4, stalls[i]);
        end
        check("bp_stall2", stalls[2], 0);
        check("bp_stall3", stalls[3], 0);
        check("bp_stall4", stalls[4], 4);
        count_busy(n);
        check("bp_drained", n < 100, 1);
        check("bp_sb_empty", sb.size(), 0);

        // Reset mid-grant with one beat still buffered
        ack_wait = 100;
        send(3'd3, 8'h08, 0, st);
        send(3'd4, 8'h10, 0, st);
        step();
        check("pre_rst_gv", s_gv, 1);
        mon_en = 1'b0;
        rst = 1'b1;
        step();
        check("mid_rst_ready", s_ready, 0);
        rst = 1'b0;
        step();
        check("post_rst_grant", s_grant, 0);
        check("post_rst_gv", s_gv, 0);
        check("post_rst_busy", s_busy, 0);
        saw = 1'b0;
        repeat (10) begin
            step();
            saw = saw | s_gv;
        end
        check("no_stale_grant", saw, 0);
        sb.delete();
        prev_gv = 1'b0;
        b2b_pending = 1'b0;
        mon_en = 1'b1;
        ack_wait = 0;

        // Early ack, HOLD=4: grant still lasts four cycles
        b2.grant_ack = 1'b1;
        b2.enc = 3'd2;
        b2.valid = 1'b1;
        step();
        check("d2_ready", s2_ready, 1);
        b2.valid = 1'b0;
        n = 0;
        g2 = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s2_gv) begin
                n++;
                g2 = s2_grant;
            end
        end
        check("d2_hold_len", n, H2);
        check("d2_grant", g2, 6'h04);

        // Out-of-range index on WIDTH=6
        b2.enc = 3'd7;
        b2.valid = 1'b1;
        step();
        check("oor_ready", s2_ready, 1);
        b2.valid = 1'b0;
        step();
`ifdef PRIO_DEC_RANGE_CHECK_EN
        check("oor_err_pulse", s2_err, 1);
        step();
        check("oor_err_end", s2_err, 0);
        saw = 1'b0;
        repeat (8) begin
            step();
            saw = saw | s2_gv;
        end
        check("oor_no_grant", saw, 0);
`else
        check("oor_err_tied", s2_err, 0);
        saw = 1'b0;
        g2 = 6'h3f;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s2_gv && !saw) begin
                saw = 1'b1;
                g2 = s2_grant;
            end
        end
        check("oor_gv", saw, 1);
        check("oor_grant_zero", g2, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
